// File: rtl/adder_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding and default operand width.
package adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder; the only arithmetic cell in the serial datapath.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (b & cin) | (a & cin);

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: walks one full-adder cell over WIDTH cycles, LSB first, with a
// registered carry, behind a start/ready handshake and a one-cycle done pulse.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | waiting for start; ready=1
//   RUN     | one operand bit pair added per cycle; busy=1
//   DONE    | sum/cout just updated; done=1 for this single cycle
module bit_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] psum_next;
    logic             cy;
    logic [CW-1:0]    cnt;
    logic             cell_s;
    logic             cell_c;
    logic             last_bit;

    full_adder_cell u_cell (
        .a    (ra[0]),
        .b    (rb[0]),
        .cin  (cy),
        .sum  (cell_s),
        .cout (cell_c)
    );

    // The new bit enters at the MSB so that after WIDTH shifts the LSB sits at bit 0.
    if (WIDTH == 1) begin : g_psum_w1
        assign psum_next = cell_s;
    end else begin : g_psum_wn
        assign psum_next = {cell_s, psum[WIDTH-1:1]};
    end

    assign last_bit = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = ST_IDLE;
        case (state)
            ST_IDLE: state_next = start ? ST_RUN : ST_IDLE;
            ST_RUN:  state_next = last_bit ? ST_DONE : ST_RUN;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ready = (state == ST_IDLE);
        busy  = (state == ST_RUN);
        done  = (state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ra   <= '0;
            rb   <= '0;
            psum <= '0;
            cy   <= 1'b0;
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ra  <= a;
                        rb  <= b;
                        cy  <= cin;
                        cnt <= '0;
                    end
                end
                ST_RUN: begin
                    ra   <= ra >> 1;
                    rb   <= rb >> 1;
                    psum <= psum_next;
                    cy   <= cell_c;
                    // Holding cnt on the last bit keeps it inside its range for any WIDTH.
                    if (last_bit) begin
                        sum  <= psum_next;
                        cout <= cell_c;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Bench for bit_serial_adder: table-driven WIDTH=8 vectors, handshake/abort sequences,
// and exhaustive WIDTH=1 and WIDTH=3 sweeps, with results scored from queues on done.
module tb_bit_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start8, cin8, ready8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start1, cin1, ready1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;
    logic       start3, cin3, ready3, busy3, done3, cout3;
    logic [2:0] a3, b3, sum3;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] q8[$];
    logic [3:0] q3[$];
    logic [1:0] q1[$];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    vec_t vecs[7];

    bit_serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    bit_serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .ready(ready1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    bit_serial_adder #(.WIDTH(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .cin(cin3),
        .ready(ready3), .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboards: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done8) begin
            if (q8.size() == 0) check("done8_unexpected", 32'd1, 32'd0);
            else check("result8", {23'd0, cout8, sum8}, {23'd0, q8.pop_front()});
        end
        if (rst_n && done3) begin
            if (q3.size() == 0) check("done3_unexpected", 32'd1, 32'd0);
            else check("result3", {28'd0, cout3, sum3}, {28'd0, q3.pop_front()});
        end
        if (rst_n && done1) begin
            if (q1.size() == 0) check("done1_unexpected", 32'd1, 32'd0);
            else check("result1", {30'd0, cout1, sum1}, {30'd0, q1.pop_front()});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready8();
        for (int i = 0; i < 40 && !ready8; i++) step();
        check("ready8_timeout", {31'd0, ready8}, 32'd1);
    endtask

    // One WIDTH=8 addition with full latency checking; operands are scrambled after acceptance.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic [8:0] exp);
        wait_ready8();
        start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
        @(posedge clk);
        q8.push_back(exp);
        #1;
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        for (int k = 0; k < 8; k++) begin
            check("busy8_run", {31'd0, busy8}, 32'd1);
            check("done8_early", {31'd0, done8}, 32'd0);
            step();
        end
        check("done8_pulse", {31'd0, done8}, 32'd1);
        check("busy8_in_done", {31'd0, busy8}, 32'd0);
        step();
        check("done8_one_cycle", {31'd0, done8}, 32'd0);
        check("ready8_after_done", {31'd0, ready8}, 32'd1);
        check("sum8_held", {23'd0, cout8, sum8}, {23'd0, exp});
    endtask

    task automatic run_small(input int w, input logic [2:0] a, input logic [2:0] b, input logic c);
        logic [3:0] exp;
        exp = 4'(a) + 4'(b) + 4'(c);
        if (w == 1) begin
            start1 = 1'b1; a1 = a[0]; b1 = b[0]; cin1 = c;
        end else begin
            start3 = 1'b1; a3 = a; b3 = b; cin3 = c;
        end
        @(posedge clk);
        if (w == 1) q1.push_back(2'(exp));
        else        q3.push_back(exp);
        #1;
        start1 = 1'b0; start3 = 1'b0;
        for (int k = 0; k < w; k++) begin
            check("busy_small", {31'd0, (w == 1) ? busy1 : busy3}, 32'd1);
            step();
        end
        check("done_small", {31'd0, (w == 1) ? done1 : done3}, 32'd1);
        step();
        check("ready_small", {31'd0, (w == 1) ? ready1 : ready3}, 32'd1);
    endtask

    initial begin
        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};

        rst_n = 1'b0;
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        start3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0;
        repeat (3) step();
        check("rst_ready8", {31'd0, ready8}, 32'd1);
        check("rst_busy8", {31'd0, busy8}, 32'd0);
        check("rst_done8", {31'd0, done8}, 32'd0);
        check("rst_sum8", {23'd0, cout8, sum8}, 32'd0);
        check("rst_ready3", {31'd0, ready3}, 32'd1);
        start8 = 1'b0;
        rst_n = 1'b1;
        step();

        foreach (vecs[i]) run8(vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].cout, vecs[i].sum});

        // start held high; operands change after acceptance, second request waits for IDLE
        wait_ready8();
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
        @(posedge clk);
        q8.push_back(9'h030);
        #1;
        a8 = 8'hAA; b8 = 8'h55;
        for (int k = 0; k < 8; k++) begin
            check("held_busy", {31'd0, busy8}, 32'd1);
            step();
        end
        check("held_done", {31'd0, done8}, 32'd1);
        step();
        check("held_ready", {31'd0, ready8}, 32'd1);
        check("held_sum", {23'd0, cout8, sum8}, 32'h030);
        step();
        q8.push_back(9'h0FF);
        check("held_second_accept", {31'd0, busy8}, 32'd1);
        start8 = 1'b0;
        wait_ready8();

        // abort after four bits: no done, outputs back to reset values
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (4) step();
        check("abort_busy_before", {31'd0, busy8}, 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("abort_ready", {31'd0, ready8}, 32'd1);
        check("abort_done", {31'd0, done8}, 32'd0);
        check("abort_sum", {23'd0, cout8, sum8}, 32'd0);
        for (int k = 0; k < 12; k++) begin
            check("abort_no_done", {31'd0, done8}, 32'd0);
            step();
        end
        run8(8'hC3, 8'h5D, 1'b1, 9'h121);

        for (int ab = 0; ab < 4; ab++)
            for (int c = 0; c < 2; c++)
                run_small(1, 3'(ab & 1), 3'((ab >> 1) & 1), 1'(c));
        for (int av = 0; av < 8; av++)
            for (int bv = 0; bv < 8; bv++)
                for (int c = 0; c < 2; c++)
                    run_small(3, 3'(av), 3'(bv), 1'(c));

        repeat (2) step();
        check("q8_drained", q8.size(), 32'd0);
        check("q3_drained", q3.size(), 32'd0);
        check("q1_drained", q1.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bit_serial_adder.md
# bit_serial_adder

Multi-bit adder that sequences a single one-bit full-adder cell over WIDTH cycles, LSB first, with a registered carry between bits. It trades latency for area: one adder cell, three shift registers, a bit counter and a small FSM. Upstream logic uses a start/ready handshake; downstream logic reads the result when done pulses. It is the sequencing controller for the basic full-adder datapath cell.

## Interface
- WIDTH, default 8: operand and sum width in bits; legal range WIDTH ≥ 1.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  input  1  request to begin an addition; accepted only when ready=1.
- a  input  WIDTH  operand A; sampled on the accepting edge only.
- b  input  WIDTH  operand B; sampled on the accepting edge only.
- cin  input  1  carry-in; sampled on the accepting edge only.
- ready  output  1  high in IDLE; the block can accept start.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse in DONE; sum and cout are valid.
- sum  output  WIDTH  registered result; held until the next completion or reset.
- cout  output  1  registered final carry-out; held with sum.

## Operation
- The FSM has three states: IDLE, RUN and DONE. Outputs decode from state: ready=IDLE, busy=RUN, done=DONE.
- IDLE, on start=1 at an edge:
  - Load shift register ra←a and rb←b.
  - Load the carry register cy←cin.
  - Set cnt←0 and go to RUN.
  - With start=0, stay in IDLE.
- RUN, at every edge:
  - The cell computes s=ra[0]^rb[0]^cy and c=(ra[0]&rb[0])|(rb[0]&cy)|(ra[0]&cy).
  - ra and rb shift right by one (zero fill).
  - The partial-sum register shifts right with s entering at bit WIDTH-1.
  - Update cy←c and cnt←cnt+1.
- Completion, at the RUN edge where cnt==WIDTH-1:
  - Copy the final partial sum, including this edge's s, into sum.
  - Load cout←c.
  - Go to DONE.
- DONE: unconditionally go to IDLE at the next edge.
- start is ignored in RUN and DONE. No queuing; the requester must wait for ready.
- Operands are captured at acceptance, so changes to a, b or cin after acceptance have no effect.
- Arithmetic is unsigned modulo 2^WIDTH. {cout,sum} = a+b+cin exactly.
- cnt is max(1,$clog2(WIDTH)) bits wide. It never wraps, because it is compared against WIDTH-1.
- WIDTH=1: exactly one RUN cycle, then DONE.

## Timing
- Reset values: state=IDLE, ready=1, busy=0, done=0, sum=0, cout=0. Internal ra, rb, cy, cnt and the partial sum are also cleared.
- Reset mid-operation (rst_n=0 in RUN or DONE) aborts the operation. At that edge all outputs take their reset values. No done pulse occurs for the aborted operation.
- Latency:
  - start is sampled at edge E0.
  - busy is high from after E0 until edge E0+WIDTH.
  - done is high for the single cycle between edges E0+WIDTH and E0+WIDTH+1.
  - ready returns after edge E0+WIDTH+1.
- Throughput: one addition per WIDTH+2 cycles, counting the acceptance edge and the DONE cycle.
- Back-to-back: start may be held high. It is then accepted at the first edge where the state is IDLE.
- sum and cout change only at the completion edge or at reset. They are stable in DONE and in the following IDLE period.
- rst_n=0 together with start=1: reset wins.

## Structure
- Shared package/header adder_pkg holds:
  - state encoding localparams: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - the default WIDTH constant.
- The encoding 2'd3 is unreachable. It decodes to IDLE on the next edge.
- One sub-module, full_adder_cell (a, b, cin → sum, cout): purely combinational and instantiated once.
- Everything else is in bit_serial_adder: the FSM, cnt, the ra, rb and partial-sum shift registers, cy, and the output registers.

## Test plan
- WIDTH=8; a=0x5A, b=0x3C, cin=0; start at E0 → busy high for 8 cycles; done pulses once after edge E0+8; sum=0x96, cout=0.
- Carry ripple through all bits:
  - a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1;
  - a=0xFF, b=0x00, cin=1 → sum=0x00, cout=1.
- start held high and operands changed during RUN (a=0x10, b=0x20 accepted, then changed to 0xAA/0x55) → result is 0x30, cout=0; second start is accepted only after DONE.
- rst_n=0 for one cycle during RUN after 4 bits → done never pulses; ready=1, sum=0, cout=0; a new start then completes normally.
- Exhaustive check with WIDTH=1 and WIDTH=3: every a, b and cin combination → {cout,sum} = a+b+cin; done after 2 and 4 edges respectively.
